// File: rtl/trip_pkg.sv
// Shared definitions for the RF trip detector and its sequencing controller.
// Holds the controller state encoding, the default peak width and a helper.
// Contents: state_t (IDLE..LOCKOUT, 3 bits), DW_DEFAULT, sat_inc8().
package trip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ARMED   = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam int DW_DEFAULT = 12;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trip_arm_ctl_if.sv
// Operator, detector and status signals of the trip sequencing controller.
// master: the controller (samples requests/detector, drives gate/lines/status).
// slave: the environment (drives requests/detector, observes the rest).
interface trip_arm_ctl_if
    import trip_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) ();
    logic          arm;
    logic          disarm;
    logic          auto_rearm;
    logic          tripped;
    logic [DW-1:0] peak_val;
    logic          gate;
    logic          trip_reset;
    logic          trip_clear;
    logic          rf_permit;
    logic [2:0]    state;
    logic [7:0]    trip_count;
    logic [DW-1:0] trip_peak;
    logic [DW-1:0] run_peak;
    logic          lockout;

    modport master (
        input  arm, disarm, auto_rearm, tripped, peak_val,
        output gate, trip_reset, trip_clear, rf_permit, state,
               trip_count, trip_peak, run_peak, lockout
    );

    modport slave (
        output arm, disarm, auto_rearm, tripped, peak_val,
        input  gate, trip_reset, trip_clear, rf_permit, state,
               trip_count, trip_peak, run_peak, lockout
    );
endinterface

// File: rtl/trip_gate_gen.sv
// Detector window strobe: modulo-PERIOD counter, gate high when count is 0.
// Latency: registered; the strobe follows run by one clock (first strobe on the first running cycle).
// No backpressure; run low holds the count at 0 and the strobe low.
// Ports: clk, reset_n, run (controller will be out of IDLE next cycle), gate (strobe).
module trip_gate_gen #(
    parameter int PERIOD = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic gate
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          run_q;

    // The count restarts at 0 on the first running cycle, so every window
    // sequence begins with a strobe.
    always_comb begin
        cnt_d = '0;
        if (run && run_q) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            gate  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run;
            gate  <= run && (cnt_d == '0);
        end
    end
endmodule

// File: rtl/trip_arm_ctl.sv
// Trip detector sequencer: gate, settle/arm, trip capture, holdoff, retry, lockout.
// Latency: all outputs registered; a request or trip sampled on one edge shows on the next.
// No backpressure; disarm overrides arm and any pending transition.
// Ports: clk, reset_n, bus (master modport: arm/disarm/auto_rearm/tripped/peak_val in;
//        gate/trip_reset/trip_clear/rf_permit/state/trip_count/trip_peak/run_peak/lockout out).
module trip_arm_ctl
    import trip_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int GATE_PERIOD = 7,
    parameter int SETTLE_CYC  = 16,
    parameter int HOLDOFF_CYC = 32,
    parameter int MAX_RETRY   = 3,
    parameter int PEAK_GATES  = 8
) (
    input logic            clk,
    input logic            reset_n,
    trip_arm_ctl_if.master bus
);
    localparam int TMAX = (SETTLE_CYC > HOLDOFF_CYC) ? SETTLE_CYC : HOLDOFF_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (PEAK_GATES > 1) ? $clog2(PEAK_GATES) : 1;
    localparam logic [PW-1:0] PK_LAST   = PW'(PEAK_GATES - 1);
    localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] pk_cnt_q;
    logic [7:0]    trip_count_q;
    logic [DW-1:0] trip_peak_q, run_peak_q;
    logic          trip_reset_q, trip_clear_q, rf_permit_q, lockout_q;
    logic          trip_reset_d, trip_clear_d, rf_permit_d, lockout_d;
    logic          gate_q;
    logic          count_clr, trip_hit, clear_fire;

    trip_gate_gen #(.PERIOD(GATE_PERIOD)) u_gate (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state_d != ST_IDLE),
        .gate    (gate_q)
    );

    always_comb begin
        state_d   = state_q;
        count_clr = 1'b0;
        trip_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d   = ST_SETTLE;
                    count_clr = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.tripped) begin
                    state_d  = ST_HOLDOFF;
                    trip_hit = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == '0) begin
                    // trip_count already includes the trip that caused this holdoff.
                    state_d = (bus.auto_rearm && trip_count_q <= RETRY_LIM) ? ST_SETTLE
                                                                             : ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (bus.arm) begin
                    state_d   = ST_SETTLE;
                    count_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.disarm) begin
            state_d   = ST_IDLE;
            count_clr = 1'b0;
            trip_hit  = 1'b0;
        end

        // Periodic clear after the PEAK_GATES-th strobe; dropped when this cycle
        // trips or leaves ARMED so the detector peak survives for trip capture.
        clear_fire = (state_q == ST_ARMED) && (state_d == ST_ARMED) &&
                     gate_q && (pk_cnt_q == PK_LAST);

        trip_reset_d = 1'b0;
        trip_clear_d = 1'b0;
        rf_permit_d  = 1'b0;
        lockout_d    = 1'b0;
        case (state_d)
            ST_IDLE, ST_SETTLE: begin
                trip_reset_d = 1'b1;
                trip_clear_d = 1'b1;
            end
            ST_ARMED: begin
                rf_permit_d  = 1'b1;
                trip_clear_d = clear_fire;
            end
            ST_LOCKOUT: begin
                lockout_d    = 1'b1;
                trip_reset_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pk_cnt_q     <= '0;
            trip_count_q <= '0;
            trip_peak_q  <= '0;
            run_peak_q   <= '0;
            trip_reset_q <= 1'b1;
            trip_clear_q <= 1'b1;
            rf_permit_q  <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trip_reset_q <= trip_reset_d;
            trip_clear_q <= trip_clear_d;
            rf_permit_q  <= rf_permit_d;
            lockout_q    <= lockout_d;

            // One down-counter serves both SETTLE and HOLDOFF; it is loaded so
            // that the zero cycle is the last cycle spent in the state.
            if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
                timer_q <= TW'(SETTLE_CYC - 1);
            end else if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF) begin
                timer_q <= TW'(HOLDOFF_CYC - 1);
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TW'(1);
            end

            // Strobes seen since entering ARMED, modulo PEAK_GATES.
            if (state_q != ST_ARMED) begin
                pk_cnt_q <= '0;
            end else if (gate_q) begin
                pk_cnt_q <= (pk_cnt_q == PK_LAST) ? '0 : pk_cnt_q + PW'(1);
            end

            if (count_clr) begin
                trip_count_q <= '0;
            end else if (trip_hit) begin
                trip_count_q <= sat_inc8(trip_count_q);
            end

            if (trip_hit)   trip_peak_q <= bus.peak_val;
            // Loaded on the edge that raises trip_clear: the detector has not
            // yet seen the clear, so this is the pre-clear peak.
            if (clear_fire) run_peak_q  <= bus.peak_val;
        end
    end

    assign bus.gate       = gate_q;
    assign bus.trip_reset = trip_reset_q;
    assign bus.trip_clear = trip_clear_q;
    assign bus.rf_permit  = rf_permit_q;
    assign bus.state      = state_q;
    assign bus.trip_count = trip_count_q;
    assign bus.trip_peak  = trip_peak_q;
    assign bus.run_peak   = run_peak_q;
    assign bus.lockout    = lockout_q;
endmodule

// File: tb/tb_trip_arm_ctl.sv
// Bench for trip_arm_ctl: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural model.
// Ports: none (top-level bench).
module tb_trip_arm_ctl;
    localparam int DW = 12;
    localparam int GP = 7;
    localparam int SC = 16;
    localparam int HC = 32;
    localparam int MR = 3;
    localparam int PG = 8;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    trip_arm_ctl_if #(.DW(DW)) bus ();

    trip_arm_ctl #(
        .DW(DW), .GATE_PERIOD(GP), .SETTLE_CYC(SC),
        .HOLDOFF_CYC(HC), .MAX_RETRY(MR), .PEAK_GATES(PG)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0..4, age = cycles already spent in the mode,
    // run = cycles since leaving IDLE (gate when run is a multiple of GP).
    int m_mode, m_age, m_run, m_strobes, m_count, m_tpeak, m_rpeak;
    bit m_pulse;
    int nm;
    bit gate_now, fire;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_age = 0; m_run = 0; m_strobes = 0;
            m_count = 0; m_tpeak = 0; m_rpeak = 0; m_pulse = 0;
        end else begin
            gate_now = (m_mode != 0) && (m_run % GP == 0);
            nm = m_mode;
            case (m_mode)
                0: if (bus.arm) nm = 1;
                1: if (m_age == SC - 1) nm = 2;
                2: if (bus.tripped) nm = 3;
                3: if (m_age == HC - 1) nm = (bus.auto_rearm && m_count <= MR) ? 1 : 4;
                4: if (bus.arm) nm = 1;
                default: nm = 0;
            endcase
            if (bus.disarm) nm = 0;
            if (!bus.disarm && (m_mode == 0 || m_mode == 4) && bus.arm) m_count = 0;
            if (!bus.disarm && m_mode == 2 && bus.tripped) begin
                m_count = (m_count >= 255) ? 255 : m_count + 1;
                m_tpeak = int'(bus.peak_val);
            end
            fire = 0;
            if (m_mode == 2 && gate_now) begin
                m_strobes++;
                if (nm == 2 && m_strobes % PG == 0) fire = 1;
            end
            if (fire) m_rpeak = int'(bus.peak_val);
            m_pulse = fire;
            if (nm == 2 && m_mode != 2) m_strobes = 0;
            m_run = (nm == 0 || m_mode == 0) ? 0 : m_run + 1;
            m_age = (nm == m_mode) ? m_age + 1 : 0;
            m_mode = nm;
        end
    end

    // Compare process: every output, every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_state",      bus.state,      m_mode);
            chk("m_gate",       bus.gate,       (m_mode != 0) && (m_run % GP == 0));
            chk("m_trip_reset", bus.trip_reset, m_mode == 0 || m_mode == 1 || m_mode == 4);
            chk("m_trip_clear", bus.trip_clear, m_mode == 0 || m_mode == 1 || (m_mode == 2 && m_pulse));
            chk("m_rf_permit",  bus.rf_permit,  m_mode == 2);
            chk("m_lockout",    bus.lockout,    m_mode == 4);
            chk("m_trip_count", bus.trip_count, m_count);
            chk("m_trip_peak",  bus.trip_peak,  m_tpeak);
            chk("m_run_peak",   bus.run_peak,   m_rpeak);
        end
    end

    // Apply inputs at a falling edge, return at the next falling edge.
    task automatic step(input bit a, input bit d, input bit ar, input bit tr, input int pv);
        bus.arm        = a;
        bus.disarm     = d;
        bus.auto_rearm = ar;
        bus.tripped    = tr;
        bus.peak_val   = DW'(pv);
        @(negedge clk);
    endtask

    int  n, gap, first_clr, pulses, last_gate, gate_gap, rearms, prev_state, pv;
    bit  gate_seen, ar, tr;

    initial begin
        reset_n = 1'b0;
        bus.arm = 0; bus.disarm = 0; bus.auto_rearm = 0; bus.tripped = 0; bus.peak_val = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset: nothing moves.
        gate_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0, 0);
            if (bus.gate) gate_seen = 1;
        end
        chk("idle_state", bus.state, 0);
        chk("idle_gate_never", gate_seen, 0);
        chk("idle_trip_reset", bus.trip_reset, 1);
        chk("idle_trip_clear", bus.trip_clear, 1);
        chk("idle_rf_permit", bus.rf_permit, 0);

        // Arm: 16 SETTLE cycles then ARMED with RF permitted.
        step(1, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 40 && bus.state == 1; i++) begin
            n++;
            step(0, 0, 0, 0, 0);
        end
        chk("settle_len", n, 16);
        chk("armed_state", bus.state, 2);
        chk("armed_permit", bus.rf_permit, 1);

        // Ramp the peak; periodic clear every 8 strobes, run_peak = pre-clear peak.
        pv = 100; pulses = 0; first_clr = 0; gap = 0; last_gate = -1; gate_gap = 0;
        for (int i = 0; i < 200 && pulses < 2; i++) begin
            pv = pv + 3;
            step(0, 0, 0, 0, pv);
            if (bus.gate) begin
                if (last_gate >= 0) gate_gap = i - last_gate;
                last_gate = i;
            end
            if (bus.trip_clear) begin
                chk("run_peak_capture", bus.run_peak, pv);
                if (pulses == 0) first_clr = i; else gap = i - first_clr;
                pulses++;
            end
        end
        chk("clear_period", gap, 56);
        chk("gate_period", gate_gap, 7);

        // Trip at peak 1167 with no auto re-arm -> holdoff then lockout.
        step(0, 0, 0, 1, 1167);
        chk("trip_permit", bus.rf_permit, 0);
        chk("trip_peak", bus.trip_peak, 1167);
        chk("trip_count", bus.trip_count, 1);
        repeat (31) step(0, 0, 0, 1, 5);
        chk("holdoff_last", bus.state, 3);
        step(0, 0, 0, 1, 5);
        chk("lockout_state", bus.state, 4);
        chk("lockout_flag", bus.lockout, 1);

        // Re-trip on every arm with auto re-arm: three retries, fourth trip locks out.
        step(1, 0, 1, 1, 500);
        chk("relock_arm_state", bus.state, 1);
        chk("relock_arm_count", bus.trip_count, 0);
        rearms = 0;
        prev_state = 1;
        for (int i = 0; i < 1000 && bus.state != 4; i++) begin
            step(0, 0, 1, 1, 500);
            if (prev_state == 3 && bus.state == 1) rearms++;
            prev_state = int'(bus.state);
        end
        chk("retry_lockout", bus.state, 4);
        chk("retry_count", bus.trip_count, 4);
        chk("retry_rearms", rearms, 3);
        step(1, 0, 1, 0, 0);
        chk("unlock_state", bus.state, 1);
        chk("unlock_count", bus.trip_count, 0);

        // Disarm, then arm+disarm together in IDLE.
        step(0, 1, 0, 0, 0);
        chk("disarm_idle", bus.state, 0);
        step(1, 1, 0, 0, 0);
        chk("arm_disarm_same", bus.state, 0);

        // Disarm during HOLDOFF keeps the trip count.
        step(1, 0, 0, 1, 77);
        for (int i = 0; i < 100 && bus.state != 3; i++) step(0, 0, 0, 1, 77);
        chk("pre_disarm_holdoff", bus.state, 3);
        step(0, 1, 0, 1, 0);
        chk("holdoff_disarm_state", bus.state, 0);
        chk("holdoff_disarm_count", bus.trip_count, 1);

        // Asynchronous reset in the middle of SETTLE.
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        chk("mid_settle", bus.state, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_gate", bus.gate, 0);
        chk("rst_trip_reset", bus.trip_reset, 1);
        chk("rst_trip_clear", bus.trip_clear, 1);
        chk("rst_rf_permit", bus.rf_permit, 0);
        chk("rst_lockout", bus.lockout, 0);
        chk("rst_trip_count", bus.trip_count, 0);
        chk("rst_trip_peak", bus.trip_peak, 0);
        chk("rst_run_peak", bus.run_peak, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized run against the model.
        ar = 1; tr = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) ar = ~ar;
            if (!tr) tr = ($urandom_range(0, 149) == 0);
            else     tr = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, ar, tr,
                 int'($urandom_range(0, 4095)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trip_arm_ctl.md
Name: trip_arm_ctl

Overview:
Sequencing controller for the single-channel RF trip detector (square-sum over a gated window, threshold compare, latched trip, peak tracker).
- Generates the detector's window gate and drives its reset and clear lines.
- Arms the detector after a settle interval and drops RF permit on a trip.
- Captures the peak value at trip time and periodically during normal running.
- Runs holdoff, automatic re-arm with a retry limit, and operator lockout.

Parameters:
DW, 12, width of the detector peak value and of the captured peaks
GATE_PERIOD, 7, cycles per detector window; gate strobe period
SETTLE_CYC, 16, cycles the detector is held in reset/clear after arming
HOLDOFF_CYC, 32, cycles after a trip before a re-arm decision
MAX_RETRY, 3, automatic re-arms allowed before lockout
PEAK_GATES, 8, gate strobes between periodic peak captures while ARMED

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
arm  in  1  one-cycle arm request (operator)
disarm  in  1  one-cycle disarm request; priority over arm
auto_rearm  in  1  level; enables automatic retry after holdoff
tripped  in  1  detector trip status
peak_val  in  DW  detector running peak
gate  out  1  window strobe to detector
trip_reset  out  1  detector trip-latch reset
trip_clear  out  1  detector peak clear
rf_permit  out  1  RF drive permitted
state  out  3  FSM state code for status readout
trip_count  out  8  trips since last operator arm, saturating at 255
trip_peak  out  DW  peak_val captured on the trip cycle
run_peak  out  DW  most recent periodic peak capture
lockout  out  1  high in LOCKOUT

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE(0); trip_reset = 1; trip_clear = 1.
  - gate, rf_permit, lockout = 0.
  - trip_count, trip_peak, run_peak = 0.
- State codes: IDLE = 0, SETTLE = 1, ARMED = 2, HOLDOFF = 3, LOCKOUT = 4.
- Gate counter:
  - Counts 0..GATE_PERIOD-1 and wraps.
  - gate = 1 for the one cycle when the count is 0.
  - The counter is held at 0 and gate = 0 in IDLE; it free-runs in all other states.
- IDLE:
  - trip_reset = trip_clear = 1.
  - arm -> SETTLE; trip_count is cleared to 0 on that transition.
- SETTLE:
  - trip_reset = trip_clear = 1.
  - The settle counter loads SETTLE_CYC-1 on entry.
  - At 0 -> ARMED.
  - Entry to ARMED occurs SETTLE_CYC cycles after entry to SETTLE.
- ARMED:
  - trip_reset = 0; rf_permit = 1.
  - trip_clear pulses for one cycle after each PEAK_GATES-th gate strobe.
  - run_peak loads peak_val in the same cycle as that trip_clear pulse, i.e. the peak before the clear takes effect.
  - tripped = 1 -> HOLDOFF. In the next cycle:
    - rf_permit = 0.
    - trip_peak captures peak_val sampled with tripped.
    - trip_count increments, saturating at 255.
  - A periodic clear coincident with the trip cycle is suppressed, so the trip peak is preserved.
- HOLDOFF:
  - rf_permit = 0; trip_reset = 0, so the latch is visible; trip_clear = 0.
  - The holdoff counter loads HOLDOFF_CYC-1 on entry.
  - At 0:
    - auto_rearm = 1 and trip_count <= MAX_RETRY -> SETTLE.
    - Otherwise -> LOCKOUT.
- LOCKOUT:
  - lockout = 1; rf_permit = 0; trip_reset = 1.
  - arm -> SETTLE and trip_count is cleared to 0.
- disarm in any state -> IDLE next cycle; rf_permit = 0 next cycle; trip_count is retained.
- arm in SETTLE, ARMED or HOLDOFF is ignored.
- arm and disarm in the same cycle: disarm wins.
- tripped already high on the first ARMED cycle -> immediate HOLDOFF (trip counted).
- Async reset at any point: immediate return to the reset values; no partial counter state survives.
- Illegal state codes recover to IDLE.

Decomposition:
- Shared package trip_pkg:
  - State encoding constants IDLE..LOCKOUT (3 bits).
  - A DW default constant used by the detector and the controller.
- One natural sub-module, trip_gate_gen: the modulo-GATE_PERIOD counter with strobe output and hold-in-idle enable.
- FSM, counters and capture registers stay in trip_arm_ctl.

Test Plan:
- Reset release, no arm for 50 cycles -> state = 0, gate never high, trip_reset = trip_clear = 1, rf_permit = 0.
- Arm pulse at cycle 10 -> state = 1 for 16 cycles, then state = 2; rf_permit = 1 from cycle 27; gate every 7 cycles.
- ARMED with peak_val ramping -> trip_clear pulses one cycle after every 8th gate (a 56-cycle period); run_peak equals peak_val in the pulse cycle.
- Detector trip with peak_val = 1167, auto_rearm = 0 -> next cycle:
  - rf_permit = 0, trip_peak = 1167, trip_count = 1.
  - 32 cycles later, state = 4 and lockout = 1.
- auto_rearm = 1 with a detector that re-trips on every arm -> 3 automatic re-arms, 4th trip -> LOCKOUT with trip_count = 4; arm -> trip_count = 0, SETTLE.
- Boundary cases:
  - arm and disarm in the same cycle while in IDLE -> state stays 0.
  - disarm during HOLDOFF -> IDLE next cycle.
  - reset_n low mid-SETTLE -> all outputs return to reset values asynchronously.
